// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Digit word layout: [3:0] hex value, [4] decimal point, [5] blank.
package disp_pkg;

    // Prefixed so the names never collide with the BLANK timing parameter.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_DRIVE
    } state_e;

    // Active-high a..g codes, entry n is the glyph for hex n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    localparam int HEX_LSB = 0;
    localparam int DP_BIT  = 4;
    localparam int BLK_BIT = 5;

    localparam logic [5:0] DIG_BLANK = 6'b100000;

endpackage

// File: rtl/seg7_decode.sv
// Digit word to active-high segment code; pad polarity is applied by the caller.
// The blank bit clears a..g but leaves the decimal point alone.
module seg7_decode
    import disp_pkg::*;
(
    input  logic [5:0] dig_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o      = 8'h00;
        seg_o[6:0] = SEG_LUT[dig_i[HEX_LSB +: 4]];
        if (dig_i[BLK_BIT]) begin
            seg_o[6:0] = 7'h00;
        end
        seg_o[7] = dig_i[DP_BIT];
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Frame-scheduled scan controller: digit sequencing, dwell/blank timing,
// and a shadow/active digit store that only swaps at frame boundaries.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int  DIGITS         = 4,
    parameter int  DWELL          = 50000,
    parameter int  BLANK          = 16,
    parameter int  CNT_W          = 16,
    parameter bit  SEG_ACTIVE_LOW = 1'b0,
    parameter bit  SL_ACTIVE_LOW  = 1'b1,
    localparam int IDX_W          = $clog2(DIGITS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              Wr_req,
    input  logic [IDX_W-1:0]  Wr_addr,
    input  logic [5:0]        Wr_data,
    output logic              Wr_ack,
    output logic              Frame_start,
    output logic [7:0]        Seg,
    output logic [DIGITS-1:0] Sl
);

    localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] SL_OFF   = {DIGITS{SL_ACTIVE_LOW}};
    localparam logic [CNT_W-1:0]  DWELL_TC = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0]  BLANK_TC = CNT_W'(BLANK - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    tmr_q, tmr_d;
    logic [5:0]          shadow_q [DIGITS];
    logic [5:0]          shadow_d [DIGITS];
    logic [5:0]          active_q [DIGITS];
    logic [5:0]          active_d [DIGITS];
    logic                armed_q, armed_d;
    logic                ack_q, ack_d;
    logic                fs_q, fs_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   sl_q, sl_d;

    logic                commit;
    logic                accept;
    logic                wr_hit;
    logic [5:0]          cur_dig;
    logic [7:0]          seg_raw;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        commit  = 1'b0;
        if (!Enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    idx_d   = '0;
                    tmr_d   = '0;
                    commit  = 1'b1;
                end
                ST_BLANK: begin
                    if (tmr_q == BLANK_TC) begin
                        state_d = ST_DRIVE;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (tmr_q == DWELL_TC) begin
                        state_d = ST_BLANK;
                        tmr_d   = '0;
                        if (idx_q == LAST_IDX) begin
                            idx_d  = '0;
                            commit = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // The acceptor disarms on a write and re-arms only after Wr_req drops,
    // so a request held across many cycles lands exactly once.
    always_comb begin
        accept  = Wr_req && armed_q;
        wr_hit  = accept && (32'(Wr_addr) < DIGITS);
        armed_d = armed_q;
        ack_d   = accept;
        if (accept) begin
            armed_d = 1'b0;
        end else if (!Wr_req) begin
            armed_d = 1'b1;
        end
        shadow_d = shadow_q;
        if (wr_hit) begin
            shadow_d[Wr_addr] = Wr_data;
        end
        // Committing from shadow_d makes a same-edge write part of the new frame.
        active_d = commit ? shadow_d : active_q;
        fs_d     = commit;
    end

    assign cur_dig = active_d[idx_d];

    seg7_decode u_dec (
        .dig_i (cur_dig),
        .seg_o (seg_raw)
    );

    always_comb begin
        seg_d = SEG_OFF;
        sl_d  = SL_OFF;
        if (state_d == ST_DRIVE) begin
            seg_d = seg_raw ^ SEG_OFF;
            sl_d  = (DIGITS'(1) << idx_d) ^ SL_OFF;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tmr_q   <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                shadow_q[i] <= DIG_BLANK;
                active_q[i] <= DIG_BLANK;
            end
            armed_q <= 1'b1;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
            seg_q   <= SEG_OFF;
            sl_q    <= SL_OFF;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmr_q    <= tmr_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            armed_q  <= armed_d;
            ack_q    <= ack_d;
            fs_q     <= fs_d;
            seg_q    <= seg_d;
            sl_q     <= sl_d;
        end
    end

    assign Wr_ack      = ack_q;
    assign Frame_start = fs_q;
    assign Seg         = seg_q;
    assign Sl          = sl_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: two instances (active-high and active-low segments)
// driven together and compared against a frame-position model every cycle.
module tb_disp_scan_ctrl;

    localparam int DIG   = 4;
    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = DW + BL;
    localparam int FRAME = DIG * SLOT;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Enable;
    logic       Wr_req;
    logic [1:0] Wr_addr;
    logic [5:0] Wr_data;
    logic       ack, fs, ack_n, fs_n;
    logic [7:0] seg, seg_n;
    logic [3:0] sl, sl_n;

    int total = 0;
    int bad   = 0;

    logic [6:0] lut [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [5:0] m_shadow [DIG];
    logic [5:0] m_active [DIG];
    bit         m_armed;
    bit         m_run;
    int         m_pos;
    logic [7:0] e_seg;
    logic [3:0] e_sl;
    logic       e_ack;
    logic       e_fs;

    logic [27:0] obs;
    logic [27:0] expv;
    localparam logic [27:0] RST_VAL = {8'h00, 4'hF, 2'b00, 8'hFF, 4'hF, 2'b00};

    assign obs  = {seg, sl, ack, fs, seg_n, sl_n, ack_n, fs_n};
    assign expv = {e_seg, e_sl, e_ack, e_fs, ~e_seg, e_sl, e_ack, e_fs};

    always #5 Clk = ~Clk;

    disp_scan_ctrl #(
        .DIGITS(DIG), .DWELL(DW), .BLANK(BL), .CNT_W(8),
        .SEG_ACTIVE_LOW(1'b0), .SL_ACTIVE_LOW(1'b1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable),
        .Wr_req(Wr_req), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
        .Wr_ack(ack), .Frame_start(fs), .Seg(seg), .Sl(sl)
    );

    disp_scan_ctrl #(
        .DIGITS(DIG), .DWELL(DW), .BLANK(BL), .CNT_W(8),
        .SEG_ACTIVE_LOW(1'b1), .SL_ACTIVE_LOW(1'b1)
    ) dut_n (
        .Clk(Clk), .Reset(Reset), .Enable(Enable),
        .Wr_req(Wr_req), .Wr_addr(Wr_addr), .Wr_data(Wr_data),
        .Wr_ack(ack_n), .Frame_start(fs_n), .Seg(seg_n), .Sl(sl_n)
    );

    function automatic logic [7:0] dec(input logic [5:0] d);
        logic [6:0] g;
        g = d[5] ? 7'h00 : lut[d[3:0]];
        return {d[4], g};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIG; i++) begin
            m_shadow[i] = 6'h20;
            m_active[i] = 6'h20;
        end
        m_armed = 1'b1;
        m_run   = 1'b0;
        m_pos   = 0;
        e_seg   = 8'h00;
        e_sl    = 4'hF;
        e_ack   = 1'b0;
        e_fs    = 1'b0;
    endtask

    // Frame position model: a frame is DIG slots of BL dark then DW lit cycles.
    task automatic model_step();
        logic [5:0] d;
        if (!Reset) begin
            model_reset();
            return;
        end
        e_ack = 1'b0;
        if (Wr_req && m_armed) begin
            e_ack   = 1'b1;
            m_armed = 1'b0;
            m_shadow[Wr_addr] = Wr_data;
        end else if (!Wr_req) begin
            m_armed = 1'b1;
        end
        e_fs = 1'b0;
        if (!Enable) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_pos = 0;
            e_fs  = 1'b1;
        end else begin
            m_pos = (m_pos + 1) % FRAME;
            e_fs  = (m_pos == 0);
        end
        if (e_fs) m_active = m_shadow;
        e_seg = 8'h00;
        e_sl  = 4'hF;
        if (m_run && (m_pos % SLOT) >= BL) begin
            d     = m_active[m_pos / SLOT];
            e_sl  = ~(4'b0001 << (m_pos / SLOT));
            e_seg = dec(d);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
    endtask

    task automatic do_write(input logic [1:0] a, input logic [5:0] d);
        Wr_addr = a;
        Wr_data = d;
        Wr_req  = 1'b1;
        tick();
        Wr_req  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0; Enable = 1'b0; Wr_req = 1'b0;
        Wr_addr = '0; Wr_data = '0;
        model_reset();
        #12;
        total++;
        if (obs !== RST_VAL) begin
            bad++;
            $display("FAIL rst_hold got=%h want=%h", obs, RST_VAL);
        end
        @(negedge Clk);
        Reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (obs !== RST_VAL) begin
                bad++;
                $display("FAIL rst_idle c=%0d got=%h want=%h", c, obs, RST_VAL);
            end
        end
    endtask

    task automatic test_scan();
        int fs_cnt = 0;
        int last   = -1;
        for (int k = 0; k < DIG; k++) do_write(2'(k), 6'h08);
        Enable = 1'b1;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL scan_model c=%0d got=%h want=%h", c, obs, expv);
            end
            if (sl !== 4'hF) begin
                total++;
                if (seg !== 8'h7F) begin
                    bad++;
                    $display("FAIL scan_seg c=%0d got=%h want=7f", c, seg);
                end
            end
            if (fs === 1'b1) begin
                fs_cnt++;
                if (last >= 0) begin
                    total++;
                    if (c - last != FRAME) begin
                        bad++;
                        $display("FAIL scan_period got=%0d want=%0d", c - last, FRAME);
                    end
                end
                last = c;
            end
        end
        total++;
        if (fs_cnt != 3) begin
            bad++;
            $display("FAIL scan_fs_count got=%0d want=3", fs_cnt);
        end
    endtask

    task automatic test_double_buffer();
        bit got;
        int st = 0;
        for (int c = 0; c < 2 * FRAME && sl !== 4'b1101; c++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL dbuf_model c=%0d got=%h want=%h", c, obs, expv);
            end
        end
        total++;
        if (sl !== 4'b1101) begin
            bad++;
            $display("FAIL dbuf_sync got sl=%b want sl=1101", sl);
        end
        Wr_addr = 2'd2; Wr_data = 6'h05; Wr_req = 1'b1;
        tick();
        Wr_req = 1'b0;
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL dbuf_ack got=%b want=1", ack);
        end
        // st: 0 = frame N digit 2, 1 = waiting for commit, 2 = frame N+1 digit 2
        got = 1'b0;
        for (int c = 0; c < 3 * FRAME && !got; c++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL dbuf_model2 c=%0d got=%h want=%h", c, obs, expv);
            end
            if (fs === 1'b1 && st == 1) st = 2;
            if (sl === 4'b1011 && st != 1) begin
                total++;
                if (st == 0 && seg !== 8'h7F) begin
                    bad++;
                    $display("FAIL dbuf_old got=%h want=7f", seg);
                end else if (st == 2 && seg !== 8'h6D) begin
                    bad++;
                    $display("FAIL dbuf_new got=%h want=6d", seg);
                end
                if (st == 2) got = 1'b1;
                else st = 1;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL dbuf_timeout got=0 want=1");
        end
    endtask

    task automatic test_held_req();
        int acks = 0;
        bit seen = 1'b0;
        logic [5:0] first;
        first   = 6'($urandom);
        Wr_addr = 2'd1;
        Wr_data = first;
        Wr_req  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            Wr_data = 6'($urandom);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL held_model c=%0d got=%h want=%h", c, obs, expv);
            end
            if (ack === 1'b1) acks++;
        end
        Wr_req = 1'b0;
        total++;
        if (acks != 1) begin
            bad++;
            $display("FAIL held_ack got=%0d want=1", acks);
        end
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL held_model2 c=%0d got=%h want=%h", c, obs, expv);
            end
            if (fs === 1'b1) seen = 1'b1;
            if (seen && sl === 4'b1101) begin
                total++;
                if (seg !== dec(first)) begin
                    bad++;
                    $display("FAIL held_data got=%h want=%h", seg, dec(first));
                end
            end
        end
    endtask

    task automatic test_coincident();
        logic [5:0] d;
        for (int c = 0; c < FRAME + 2 && !(m_run && m_pos == FRAME - 1); c++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL coin_model c=%0d got=%h want=%h", c, obs, expv);
            end
        end
        d = {1'b0, 1'($urandom), 4'($urandom)};
        Wr_addr = 2'd0; Wr_data = d; Wr_req = 1'b1;
        tick();
        Wr_req = 1'b0;
        total++;
        if ({fs, ack} !== 2'b11) begin
            bad++;
            $display("FAIL coin_edge got fs,ack=%b want=11", {fs, ack});
        end
        for (int c = 0; c < BL; c++) tick();
        total++;
        if (sl !== 4'b1110 || seg !== dec(d)) begin
            bad++;
            $display("FAIL coin_data got sl=%b seg=%h want sl=1110 seg=%h", sl, seg, dec(d));
        end
    endtask

    task automatic test_enable_drop();
        for (int c = 0; c < FRAME + 2 && sl !== 4'b1011; c++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL edrop_model c=%0d got=%h want=%h", c, obs, expv);
            end
        end
        Enable = 1'b0;
        tick();
        total++;
        if ({sl, seg, fs} !== {4'hF, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL edrop_off got sl=%b seg=%h fs=%b want sl=1111 seg=00 fs=0", sl, seg, fs);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL edrop_idle c=%0d got=%h want=%h", c, obs, expv);
            end
        end
        Enable = 1'b1;
        tick();
        total++;
        if ({fs, sl} !== {1'b1, 4'hF}) begin
            bad++;
            $display("FAIL edrop_restart got fs=%b sl=%b want fs=1 sl=1111", fs, sl);
        end
        for (int c = 0; c < BL; c++) tick();
        total++;
        if (sl !== 4'b1110) begin
            bad++;
            $display("FAIL edrop_digit0 got sl=%b want 1110", sl);
        end
    endtask

    task automatic test_decode();
        logic [5:0] dv [DIG];
        logic [3:0] onek;
        for (int r = 0; r < 5; r++) begin
            Enable = 1'b0;
            tick();
            for (int k = 0; k < DIG; k++) begin
                dv[k] = {1'b0, 1'($urandom), 4'(r * 4 + k)};
                if (r == 4) dv[k] = (k == 2) ? 6'b110000 : 6'($urandom);
                do_write(2'(k), dv[k]);
            end
            Enable = 1'b1;
            for (int c = 0; c < FRAME; c++) begin
                tick();
                total++;
                if (obs !== expv) begin
                    bad++;
                    $display("FAIL dec_model r=%0d c=%0d got=%h want=%h", r, c, obs, expv);
                end
                for (int k = 0; k < DIG; k++) begin
                    onek = 4'b0001 << k;
                    if (sl === ~onek) begin
                        total++;
                        if (seg !== dec(dv[k]) || seg_n !== ~dec(dv[k])) begin
                            bad++;
                            $display("FAIL dec_seg d=%h got=%h/%h want=%h", dv[k], seg, seg_n, dec(dv[k]));
                        end
                        if (dv[k] == 6'b110000) begin
                            total++;
                            if (seg !== 8'h80) begin
                                bad++;
                                $display("FAIL dec_blank got=%h want=80", seg);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) < 3) Enable = ~Enable;
            Wr_req  = ($urandom_range(0, 99) < 40);
            Wr_addr = 2'($urandom);
            Wr_data = 6'($urandom);
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL rand_model c=%0d got=%h want=%h", c, obs, expv);
            end
        end
        Wr_req = 1'b0;
        Enable = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2 * FRAME && sl !== 4'b0111; c++) tick();
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs !== RST_VAL) begin
            bad++;
            $display("FAIL rmid_async got=%h want=%h", obs, RST_VAL);
        end
        tick();
        tick();
        Reset = 1'b1;
        for (int c = 0; c < FRAME + 2; c++) begin
            tick();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL rmid_model c=%0d got=%h want=%h", c, obs, expv);
            end
            if (sl !== 4'hF) begin
                total++;
                if (seg !== 8'h00) begin
                    bad++;
                    $display("FAIL rmid_lost got=%h want=00", seg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_double_buffer();
        test_held_req();
        test_coincident();
        test_enable_drop();
        test_decode();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
